// File: rtl/channel_frame_sequencer_if.sv
// Sample-buffer read port plus AXI-Stream output of the channel frame sequencer.
// master = sequencer side, slave = buffer/downstream side.
interface channel_frame_sequencer_if #(
    parameter int CH_W   = 4,
    parameter int DATA_W = 16
);
    logic              rd_en;
    logic [CH_W-1:0]   rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] m_tdata;
    logic [CH_W-1:0]   m_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (
        output rd_en, rd_addr, m_tdata, m_tuser, m_tvalid, m_tlast,
        input  rd_data, m_tready
    );

    modport slave (
        input  rd_en, rd_addr, m_tdata, m_tuser, m_tvalid, m_tlast,
        output rd_data, m_tready
    );
endinterface

// File: rtl/channel_frame_sequencer.sv
// Walks enabled channels of a buffered frame in ascending order; 3 cycles/beat, first beat 3 cycles after accept,
// beat held until tready, all outputs registered. CHSEQ_OVERRUN_CNT_EN builds the saturating overrun counter.
module channel_frame_sequencer #(
    parameter int N_CH   = 16,
    parameter int CH_W   = 4,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic [N_CH-1:0]            ch_mask,
    channel_frame_sequencer_if.master  m,
    output logic                       busy,
    output logic [15:0]                frame_cnt,
    output logic [7:0]                 overrun_cnt
);
    typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              rd_en_q, rd_en_d;
    logic [CH_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [CH_W-1:0]   tuser_q, tuser_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              busy_q, busy_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic [CH_W-1:0]   low_ch;
    logic [CH_W-1:0]   above_ch;
    logic              above_vld;

    // Priority searches: lowest channel of the incoming mask, next channel above the current one.
    always_comb begin
        low_ch    = '0;
        above_ch  = '0;
        above_vld = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                low_ch = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(ch_q))) begin
                above_ch  = CH_W'(i);
                above_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            ch_q        <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                // An all-zero mask is not a frame; the strobe is simply dropped.
                if (frame_start && (|ch_mask)) begin
                    mask_d  = ch_mask;
                    ch_d    = low_ch;
                    state_d = READ;
                end
            end
            READ: state_d = LOAD;
            LOAD: state_d = SEND;
            SEND: begin
                if (tvalid_q && m.m_tready) begin
                    if (tlast_q) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = IDLE;
                    end else begin
                        ch_d    = above_ch;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so every port comes straight from a flop.
    always_comb begin
        rd_en_d   = (state_d == READ);
        rd_addr_d = (state_d == READ) ? ch_d : rd_addr_q;
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;
        if (state_q == LOAD) begin
            tdata_d = m.rd_data;
            tuser_d = ch_q;
            tlast_d = !above_vld;
        end
        tvalid_d = (state_d == SEND);
        busy_d   = (state_d != IDLE);
    end

`ifdef CHSEQ_OVERRUN_CNT_EN
    logic [7:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (frame_start && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_cnt = ovr_q;
`else
    assign overrun_cnt = 8'd0;
`endif

    assign m.rd_en    = rd_en_q;
    assign m.rd_addr  = rd_addr_q;
    assign m.m_tdata  = tdata_q;
    assign m.m_tuser  = tuser_q;
    assign m.m_tvalid = tvalid_q;
    assign m.m_tlast  = tlast_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: doc/channel_frame_sequencer.md
# channel_frame_sequencer

Scan controller for the Xike multi-channel acquisition path. On each frame strobe from the front end, it walks the per-frame sample buffer in ascending channel order and skips channels disabled in a mask. Each enabled channel's sample goes out as one AXI-Stream beat, tagged with its channel number, and `tlast` marks the last enabled channel. It also reports busy state, completed-frame count and dropped (overrun) frames.

## Interface
Parameters:
- `N_CH`, default 16: number of channels per frame.
- `CH_W`, default 4: channel index width; must satisfy 2^CH_W ≥ N_CH.
- `DATA_W`, default 16: sample width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_start` in 1: one-cycle pulse; a complete frame is now in the sample buffer.
- `ch_mask` in N_CH: channel enable mask, bit i = channel i; sampled only when `frame_start` is accepted.
- `rd_en` out 1: sample buffer read strobe.
- `rd_addr` out CH_W: sample buffer read address (channel index).
- `rd_data` in DATA_W: buffer read data, valid the cycle after `rd_en`.
- `m_tdata` out DATA_W: sample.
- `m_tuser` out CH_W: channel number of the current beat.
- `m_tvalid` out 1: beat valid.
- `m_tready` in 1: downstream ready.
- `m_tlast` out 1: high on the beat of the highest enabled channel.
- `busy` out 1: high in any state other than IDLE.
- `frame_cnt` out 16: completed frames; wraps.
- `overrun_cnt` out 8: dropped frame strobes; saturates.

## Operation
- FSM states are IDLE, READ, LOAD and SEND.
- IDLE:
  - A `frame_start` with a nonzero `ch_mask` is accepted: the mask is latched, the next channel is set to the lowest enabled channel, and the FSM goes to READ.
  - A `frame_start` with an all-zero mask is ignored: no beats, no counter change, stay in IDLE.
- READ (one cycle): `rd_en`=1 and `rd_addr` = current channel; go to LOAD.
- LOAD (one cycle): capture `rd_data` into `m_tdata` and the current channel into `m_tuser`. Set `m_tlast` if no enabled channel lies above the current one. Go to SEND.
- SEND:
  - `m_tvalid`=1. `m_tdata`, `m_tuser` and `m_tlast` are held stable until `m_tvalid` and `m_tready` are both high.
  - On that handshake, if `m_tlast`=0: advance to the next higher enabled channel (priority search on the latched mask above the current index) and go to READ.
  - On that handshake, if `m_tlast`=1: increment `frame_cnt` (wraps 0xFFFF→0) and go to IDLE.
- Overrun: a `frame_start` while not in IDLE increments `overrun_cnt` (saturates at 255). The frame in progress continues unchanged, and the latched mask is not updated.
- Simultaneous events: a `frame_start` in the same cycle as the final handshake counts as an overrun, because the FSM is still in SEND.
- Reset, including mid-frame:
  - FSM → IDLE; latched mask → 0.
  - All outputs go low or zero on the next edge: `m_tvalid`, `m_tlast`, `rd_en`, `rd_addr`, `m_tdata`, `m_tuser`, `busy`, `frame_cnt` and `overrun_cnt`.
  - Beats of the aborted frame are not completed.
- `rd_en` is never high outside READ. `m_tvalid` is never high outside SEND.

## Timing
- `frame_start` accepted at edge T:
  - `rd_en` high in cycle T+1.
  - `rd_data` valid in cycle T+2, captured at the end of T+2.
  - First `m_tvalid` in cycle T+3.
- Per-beat cost is 3 cycles with `m_tready` held high. A full 16-channel frame ends 48 cycles after acceptance: the last handshake is in cycle T+48, and IDLE begins at T+49.
- The earliest next accepted `frame_start` is the cycle after the final handshake.
- All outputs are registered; there is no combinational path from `m_tready` to any output.

## Configuration
- Macro `CHSEQ_OVERRUN_CNT_EN`.
- When defined: overrun detection and the saturating `overrun_cnt` counter are built as described.
- When undefined: no counter logic is built and `overrun_cnt` is tied to 0. Overrun strobes are still ignored, with identical FSM behaviour.

## Test plan
- Mask 0xFFFF, buffer value = 0x100+i, `m_tready`=1: 16 beats with `m_tuser` 0..15 and `m_tdata` 0x100..0x10F. `m_tlast` only on channel 15; first `m_tvalid` at T+3; `frame_cnt`=1.
- Mask 0x8421: exactly 4 beats, channels 0, 5, 10 and 15. `rd_addr` sequence 0, 5, 10, 15; `m_tlast` on channel 15.
- Mask 0x0001: a single beat, channel 0, with `m_tlast`=1. Mask 0x0000: no `rd_en`, `busy` stays 0, `frame_cnt` unchanged.
- `m_tready` low for 5 cycles during the channel 3 beat: `m_tdata`, `m_tuser` and `m_tlast` are stable throughout. No `rd_en` occurs until the handshake; the beat completes without loss or duplication.
- Overrun cases:
  - A `frame_start` in SEND of channel 7: `overrun_cnt`=1 and the frame completes unchanged.
  - A `frame_start` coincident with the final handshake: `overrun_cnt`=2.
  - 300 overruns: `overrun_cnt`=255. With the macro undefined, it reads 0.
- `rst` during the channel 6 beat: the next cycle shows `m_tvalid`=0, `busy`=0 and counters at 0. A following `frame_start` restarts from the lowest enabled channel.
